// File: rtl/control_unit.sv
// control_unit: multi-cycle sequencer for the fdt16 accumulator datapath.
// Sequence: IDLE -> FETCH -> DECODE -> EXEC -> [MEM] -> FETCH, HALT absorbing.
// Tracks call-stack depth and raises a sticky fault on over/underflow.
// Optional macro CU_ILLEGAL_TRAP_EN: unlisted opcodes fault and halt instead of acting as NOP.
module control_unit #(
    parameter int OPCODE_W    = 6,
    parameter int ALU_OP_W    = 4,
    parameter int STACK_DEPTH = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero_flag,
    input  logic                negative_flag,
    input  logic                carry_flag,
    input  logic                overflow_flag,
    output logic                stall,
    output logic                branch,
    output logic                ret_sel,
    output logic                acc_enable,
    output logic                flags_en,
    output logic                reg_load,
    output logic                mem_load,
    output logic                mem_store,
    output logic                push,
    output logic                pop,
    output logic                dmem_in_sel,
    output logic                src_sel,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                halted,
    output logic                fault
);

    localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);
    localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(STACK_DEPTH);

    localparam logic [OPCODE_W-1:0] OP_NOP   = OPCODE_W'(6'h00);
    localparam logic [OPCODE_W-1:0] OP_HLT   = OPCODE_W'(6'h01);
    localparam logic [OPCODE_W-1:0] OP_ADD   = OPCODE_W'(6'h02);
    localparam logic [OPCODE_W-1:0] OP_LSR   = OPCODE_W'(6'h09);
    localparam logic [OPCODE_W-1:0] OP_CMP   = OPCODE_W'(6'h0A);
    localparam logic [OPCODE_W-1:0] OP_MOV   = OPCODE_W'(6'h10);
    localparam logic [OPCODE_W-1:0] OP_LOAD  = OPCODE_W'(6'h11);
    localparam logic [OPCODE_W-1:0] OP_STORE = OPCODE_W'(6'h12);
    localparam logic [OPCODE_W-1:0] OP_BRA   = OPCODE_W'(6'h18);
    localparam logic [OPCODE_W-1:0] OP_BRZ   = OPCODE_W'(6'h19);
    localparam logic [OPCODE_W-1:0] OP_BRN   = OPCODE_W'(6'h1A);
    localparam logic [OPCODE_W-1:0] OP_BRC   = OPCODE_W'(6'h1B);
    localparam logic [OPCODE_W-1:0] OP_BRO   = OPCODE_W'(6'h1C);
    localparam logic [OPCODE_W-1:0] OP_CALL  = OPCODE_W'(6'h1D);
    localparam logic [OPCODE_W-1:0] OP_RET   = OPCODE_W'(6'h1E);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_HALT
    } state_t;

    state_t               state_q, state_d;
    logic [DEPTH_W-1:0]   depth_q, depth_d;
    logic                 fault_q, fault_d;

    logic op_alu;
    logic op_cmp;

    assign op_alu = (opcode >= OP_ADD) && (opcode <= OP_LSR);
    assign op_cmp = (opcode == OP_CMP);

    // State, stack depth and sticky fault registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            depth_q <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            depth_q <= depth_d;
            fault_q <= fault_d;
        end
    end

    // Next-state, depth tracking and per-state output decode
    always_comb begin
        state_d     = state_q;
        depth_d     = depth_q;
        fault_d     = fault_q;
        stall       = 1'b1;
        branch      = 1'b0;
        ret_sel     = 1'b0;
        acc_enable  = 1'b0;
        flags_en    = 1'b0;
        reg_load    = 1'b0;
        mem_load    = 1'b0;
        mem_store   = 1'b0;
        push        = 1'b0;
        pop         = 1'b0;
        dmem_in_sel = 1'b0;
        src_sel     = 1'b0;
        alu_op      = '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                end
            end

            S_FETCH: begin
                state_d = S_DECODE;
            end

            S_DECODE: begin
                if (op_alu || op_cmp) begin
                    alu_op = opcode[ALU_OP_W-1:0];
                end
                state_d = S_EXEC;
            end

            S_EXEC: begin
                state_d = S_FETCH;
                if (op_alu || op_cmp) begin
                    alu_op = opcode[ALU_OP_W-1:0];
                end
                if (op_alu) begin
                    acc_enable = 1'b1;
                    flags_en   = 1'b1;
                    stall      = 1'b0;
                end else if (op_cmp) begin
                    flags_en = 1'b1;
                    stall    = 1'b0;
                end else begin
                    case (opcode)
                        OP_NOP: begin
                            stall = 1'b0;
                        end
                        OP_HLT: begin
                            state_d = S_HALT;
                        end
                        OP_MOV: begin
                            src_sel  = 1'b1;
                            reg_load = 1'b1;
                            stall    = 1'b0;
                        end
                        OP_STORE: begin
                            dmem_in_sel = 1'b1;
                            mem_store   = 1'b1;
                            stall       = 1'b0;
                        end
                        OP_LOAD: begin
                            mem_load = 1'b1;
                            state_d  = S_MEM;
                        end
                        OP_BRA: begin
                            branch = 1'b1;
                            stall  = 1'b0;
                        end
                        OP_BRZ: begin
                            branch = zero_flag;
                            stall  = 1'b0;
                        end
                        OP_BRN: begin
                            branch = negative_flag;
                            stall  = 1'b0;
                        end
                        OP_BRC: begin
                            branch = carry_flag;
                            stall  = 1'b0;
                        end
                        OP_BRO: begin
                            branch = overflow_flag;
                            stall  = 1'b0;
                        end
                        OP_CALL: begin
                            // Full stack: suppress the push and trap instead
                            if (depth_q == DEPTH_MAX) begin
                                fault_d = 1'b1;
                                state_d = S_HALT;
                            end else begin
                                dmem_in_sel = 1'b0;
                                push        = 1'b1;
                                depth_d     = depth_q + 1'b1;
                                state_d     = S_MEM;
                            end
                        end
                        OP_RET: begin
                            // Empty stack: suppress the pop and trap instead
                            if (depth_q == '0) begin
                                fault_d = 1'b1;
                                state_d = S_HALT;
                            end else begin
                                pop     = 1'b1;
                                depth_d = depth_q - 1'b1;
                                state_d = S_MEM;
                            end
                        end
                        default: begin
`ifdef CU_ILLEGAL_TRAP_EN
                            fault_d = 1'b1;
                            state_d = S_HALT;
`else
                            stall = 1'b0;
`endif
                        end
                    endcase
                end
            end

            S_MEM: begin
                state_d = S_FETCH;
                case (opcode)
                    OP_LOAD: begin
                        src_sel  = 1'b0;
                        reg_load = 1'b1;
                        stall    = 1'b0;
                    end
                    OP_CALL: begin
                        branch = 1'b1;
                        stall  = 1'b0;
                    end
                    OP_RET: begin
                        ret_sel = 1'b1;
                        branch  = 1'b1;
                        stall   = 1'b0;
                    end
                    default: begin
                        stall = 1'b1;
                    end
                endcase
            end

            S_HALT: begin
                state_d = S_HALT;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // While reset is held, no pending action may leak out to the datapath
        if (!reset) begin
            stall       = 1'b1;
            branch      = 1'b0;
            ret_sel     = 1'b0;
            acc_enable  = 1'b0;
            flags_en    = 1'b0;
            reg_load    = 1'b0;
            mem_load    = 1'b0;
            mem_store   = 1'b0;
            push        = 1'b0;
            pop         = 1'b0;
            dmem_in_sel = 1'b0;
            src_sel     = 1'b0;
            alu_op      = '0;
        end
    end

    assign halted = (state_q == S_HALT);
    assign fault  = fault_q;

endmodule

// File: tb/tb_control_unit.sv
// Directed testbench for control_unit with hand-computed expected output vectors.
module tb_control_unit;

    logic       clk;
    logic       reset;
    logic       start;
    logic [5:0] opcode;
    logic       zero_flag, negative_flag, carry_flag, overflow_flag;
    logic       stall, branch, ret_sel, acc_enable, flags_en, reg_load;
    logic       mem_load, mem_store, push, pop, dmem_in_sel, src_sel;
    logic [3:0] alu_op;
    logic       halted, fault;

    int n_checks = 0;
    int n_pass   = 0;

    // Packed view of the control outputs:
    // [11] stall [10] branch [9] ret_sel [8] acc_enable [7] flags_en [6] reg_load
    // [5] mem_load [4] mem_store [3] push [2] pop [1] dmem_in_sel [0] src_sel
    logic [11:0] outvec;
    assign outvec = {stall, branch, ret_sel, acc_enable, flags_en, reg_load,
                     mem_load, mem_store, push, pop, dmem_in_sel, src_sel};

    localparam logic [11:0] V_STALL   = 12'h800;
    localparam logic [11:0] V_ALU     = 12'h180;
    localparam logic [11:0] V_CMP     = 12'h080;
    localparam logic [11:0] V_TAKEN   = 12'h400;
    localparam logic [11:0] V_ADVANCE = 12'h000;
    localparam logic [11:0] V_MOV     = 12'h041;
    localparam logic [11:0] V_STORE   = 12'h012;
    localparam logic [11:0] V_LOAD_E  = 12'h820;
    localparam logic [11:0] V_LOAD_M  = 12'h040;
    localparam logic [11:0] V_CALL_E  = 12'h808;
    localparam logic [11:0] V_CALL_M  = 12'h400;
    localparam logic [11:0] V_RET_E   = 12'h804;
    localparam logic [11:0] V_RET_M   = 12'h600;

    control_unit #(
        .OPCODE_W   (6),
        .ALU_OP_W   (4),
        .STACK_DEPTH(16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .opcode       (opcode),
        .zero_flag    (zero_flag),
        .negative_flag(negative_flag),
        .carry_flag   (carry_flag),
        .overflow_flag(overflow_flag),
        .stall        (stall),
        .branch       (branch),
        .ret_sel      (ret_sel),
        .acc_enable   (acc_enable),
        .flags_en     (flags_en),
        .reg_load     (reg_load),
        .mem_load     (mem_load),
        .mem_store    (mem_store),
        .push         (push),
        .pop          (pop),
        .dmem_in_sel  (dmem_in_sel),
        .src_sel      (src_sel),
        .alu_op       (alu_op),
        .halted       (halted),
        .fault        (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leave IDLE with the given opcode presented; ends sampled in FETCH
    task automatic begin_run(input logic [5:0] op);
        start  = 1'b1;
        opcode = op;
        tick();
        start = 1'b0;
        check("fetch_after_start", 32'(outvec), 32'(V_STALL));
    endtask

    // Run one instruction from FETCH through to the next FETCH
    task automatic exec_op(input string tag, input logic [5:0] op, input logic [11:0] exp_exec,
                           input logic [3:0] exp_alu, input bit has_mem,
                           input logic [11:0] exp_mem);
        opcode = op;
        tick();
        check({tag, "_decode"}, 32'(outvec), 32'(V_STALL));
        tick();
        check({tag, "_exec"}, 32'(outvec), 32'(exp_exec));
        check({tag, "_alu_op"}, 32'(alu_op), 32'(exp_alu));
        if (has_mem) begin
            tick();
            check({tag, "_mem"}, 32'(outvec), 32'(exp_mem));
        end
        tick();
        check({tag, "_next_fetch"}, 32'(outvec), 32'(V_STALL));
    endtask

    // Present an opcode that must trap in EXEC and leave the unit halted with fault set
    task automatic expect_trap(input string tag, input logic [5:0] op, input logic exp_fault);
        opcode = op;
        tick();
        tick();
        check({tag, "_exec"}, 32'(outvec), 32'(V_STALL));
        tick();
        check({tag, "_halted"}, 32'(halted), 32'(1));
        check({tag, "_fault"}, 32'(fault), 32'(exp_fault));
        check({tag, "_halt_out"}, 32'(outvec), 32'(V_STALL));
    endtask

    task automatic do_reset();
        reset = 1'b0;
        start = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        opcode = 6'h00;
        zero_flag = 1'b0;
        negative_flag = 1'b0;
        carry_flag = 1'b0;
        overflow_flag = 1'b0;

        // Reset state
        do_reset();
        check("reset_out", 32'(outvec), 32'(V_STALL));
        check("reset_halted", 32'(halted), 32'(0));
        check("reset_fault", 32'(fault), 32'(0));
        tick();
        check("idle_hold", 32'(outvec), 32'(V_STALL));

        // ADD: 3-cycle retirement, enables only in cycle 3
        begin_run(6'h02);
        exec_op("add", 6'h02, V_ALU, 4'h2, 1'b0, 12'h000);
        exec_op("sub", 6'h03, V_ALU, 4'h3, 1'b0, 12'h000);
        exec_op("lsr", 6'h09, V_ALU, 4'h9, 1'b0, 12'h000);
        exec_op("cmp", 6'h0A, V_CMP, 4'hA, 1'b0, 12'h000);

        // Conditional branches, start held high to show it is ignored
        start = 1'b1;
        zero_flag = 1'b1;
        exec_op("brz_taken", 6'h19, V_TAKEN, 4'h0, 1'b0, 12'h000);
        zero_flag = 1'b0;
        exec_op("brz_not", 6'h19, V_ADVANCE, 4'h0, 1'b0, 12'h000);
        start = 1'b0;
        exec_op("bra", 6'h18, V_TAKEN, 4'h0, 1'b0, 12'h000);
        carry_flag = 1'b1;
        exec_op("brc_taken", 6'h1B, V_TAKEN, 4'h0, 1'b0, 12'h000);
        carry_flag = 1'b0;
        exec_op("bro_not", 6'h1C, V_ADVANCE, 4'h0, 1'b0, 12'h000);

        // Register and memory moves
        exec_op("mov", 6'h10, V_MOV, 4'h0, 1'b0, 12'h000);
        exec_op("store", 6'h12, V_STORE, 4'h0, 1'b0, 12'h000);
        exec_op("load", 6'h11, V_LOAD_E, 4'h0, 1'b1, V_LOAD_M);
        exec_op("nop", 6'h00, V_ADVANCE, 4'h0, 1'b0, 12'h000);

        // CALL then RET, then RET on the empty stack must trap
        exec_op("call", 6'h1D, V_CALL_E, 4'h0, 1'b1, V_CALL_M);
        exec_op("ret", 6'h1E, V_RET_E, 4'h0, 1'b1, V_RET_M);
        check("fault_after_ret", 32'(fault), 32'(0));
        expect_trap("ret_underflow", 6'h1E, 1'b1);
        start = 1'b1;
        tick();
        check("halt_ignores_start", 32'(halted), 32'(1));
        start = 1'b0;

        // Reset clears fault and halt
        do_reset();
        check("reset2_halted", 32'(halted), 32'(0));
        check("reset2_fault", 32'(fault), 32'(0));

        // Sixteen CALLs fill the stack, the seventeenth traps
        begin_run(6'h1D);
        for (int i = 0; i < 16; i++) begin
            exec_op("call_fill", 6'h1D, V_CALL_E, 4'h0, 1'b1, V_CALL_M);
        end
        check("fill_no_fault", 32'(fault), 32'(0));
        expect_trap("call_overflow", 6'h1D, 1'b1);

        // Unlisted opcode
        do_reset();
        begin_run(6'h3F);
`ifdef CU_ILLEGAL_TRAP_EN
        expect_trap("illegal", 6'h3F, 1'b1);
`else
        exec_op("illegal_nop", 6'h3F, V_ADVANCE, 4'h0, 1'b0, 12'h000);
        check("illegal_no_fault", 32'(fault), 32'(0));
        check("illegal_not_halted", 32'(halted), 32'(0));

        // HLT halts without fault
        expect_trap("hlt", 6'h01, 1'b0);
`endif

        // Reset while a CALL sits in MEM drops the pending branch
        do_reset();
        begin_run(6'h1D);
        tick();
        tick();
        check("midrst_exec", 32'(outvec), 32'(V_CALL_E));
        tick();
        check("midrst_mem", 32'(outvec), 32'(V_CALL_M));
        reset = 1'b0;
        #1;
        check("midrst_gated", 32'(outvec), 32'(V_STALL));
        tick();
        reset = 1'b1;
        #1;
        check("midrst_idle", 32'(outvec), 32'(V_STALL));
        tick();
        check("midrst_stays_idle", 32'(outvec), 32'(V_STALL));
        check("midrst_fault", 32'(fault), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
